// File: rtl/uart_tx_arb.sv
// Round-robin arbiter and launch sequencer sharing one uart_tx between the CPU
// output port (requester 0) and the monitor/dump engine (requester 1).
module uart_tx_arb #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] byte0,
    output logic       ack0,
    output logic       done0,
    input  logic       req1,
    input  logic [7:0] byte1,
    output logic       ack1,
    output logic       done1,
    output logic [7:0] tx_byte,
    output logic       tx_enable,
    input  logic       tx_rdy,
    output logic       busy,
    output logic       owner,
    output logic       err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT_LO = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    logic [2:0] r_state;
    logic [7:0] r_tx_byte;
    logic       r_owner;
    logic       r_last;
    logic [3:0] r_cnt;
    logic       r_err;

    logic       w_grant;
    logic       w_winner;

    // On a tie the requester that did not finish most recently wins.
    always_comb begin
        w_winner = req1;
        if (req0 && req1) begin
            w_winner = ~r_last;
        end
        w_grant = (r_state == S_IDLE) && tx_rdy && (req0 || req1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tx_byte <= '0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_tx_byte <= w_winner ? byte1 : byte0;
                        r_owner   <= w_winner;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    // Abort compares the registered count so done lands TIMEOUT+2 after launch.
                    if (!tx_rdy) begin
                        r_state <= S_WAIT_HI;
                    end else if (r_cnt == TIMEOUT_CNT) begin
                        r_err   <= 1'b1;
                        r_last  <= r_owner;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_rdy) begin
                        r_last  <= r_owner;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from registered state only; no path from req*/tx_rdy.
    assign tx_enable = (r_state == S_START);
    assign ack0      = (r_state == S_START) && !r_owner;
    assign ack1      = (r_state == S_START) &&  r_owner;
    assign done0     = (r_state == S_DONE)  && !r_owner;
    assign done1     = (r_state == S_DONE)  &&  r_owner;
    assign busy      = (r_state != S_IDLE);
    assign owner     = r_owner;
    assign tx_byte   = r_tx_byte;
    assign err       = r_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a per-cycle vector table plus scripted
// scenarios driven against a small UART/requester model with a launch scoreboard.
module tb_uart_tx_arb;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, tx_rdy;
    logic [7:0] byte0, byte1;
    logic       ack0, ack1, done0, done1;
    logic [7:0] tx_byte;
    logic       tx_enable, busy, owner, err;

    always #5 clk = ~clk;

    uart_tx_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .byte0     (byte0),
        .ack0      (ack0),
        .done0     (done0),
        .req1      (req1),
        .byte1     (byte1),
        .ack1      (ack1),
        .done1     (done1),
        .tx_byte   (tx_byte),
        .tx_enable (tx_enable),
        .tx_rdy    (tx_rdy),
        .busy      (busy),
        .owner     (owner),
        .err       (err)
    );

    typedef struct {
        logic       rst;
        logic       r0;
        logic [7:0] b0;
        logic       r1;
        logic [7:0] b1;
        logic       rdy;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic       own;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t sb[$];
    int   uart_mode;      // 0: modelled UART, 1: dead UART, 2: tx_rdy driven by hand
    int   frame_len, uart_phase, uart_left;
    int   exp_done_cyc;
    logic exp_done_own, cur_own, held_ok;
    logic [7:0] lat_byte, val0, val1;
    int   rem0, rem1;
    int   n_en, n_ack0, n_ack1, n_done0, n_done1, t_en, t_done0, t_done1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [15:0] mk(input logic bz, input logic en, input logic a0, input logic a1,
                                       input logic d0, input logic d1, input logic own, input logic er,
                                       input logic [7:0] tb);
        return {bz, en, a0, a1, d0, d1, own, er, tb};
    endfunction

    function automatic logic [15:0] obs();
        return {busy, tx_enable, ack0, ack1, done0, done1, owner, err, tx_byte};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [7:0] b, input logic own);
        exp_t e;
        e.b = b;
        e.own = own;
        sb.push_back(e);
    endtask

    task automatic arm0(input logic [7:0] v, input int n);
        val0 = v; rem0 = n; req0 = 1'b1; byte0 = v;
    endtask

    task automatic arm1(input logic [7:0] v, input int n);
        val1 = v; rem1 = n; req1 = 1'b1; byte1 = v;
    endtask

    task automatic step();
        exp_t e;
        tick();
        if (tx_enable) begin
            n_en++;
            t_en = cyc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_launch: got tx_byte=0x%0h expected no launch (cycle %0d)", tx_byte, cyc);
            end else begin
                e = sb.pop_front();
                check("launch_byte_ack", {22'd0, tx_byte, ack1, ack0}, {22'd0, e.b, e.own, ~e.own});
                cur_own  = e.own;
                lat_byte = e.b;
                held_ok  = 1'b1;
                if (uart_mode == 1) begin
                    exp_done_cyc = cyc + TIMEOUT + 2;
                    exp_done_own = e.own;
                end
            end
        end
        if (ack0) n_ack0++;
        if (ack1) n_ack1++;
        if (done0) begin n_done0++; t_done0 = cyc; end
        if (done1) begin n_done1++; t_done1 = cyc; end
        if (busy && !tx_enable && tx_byte !== lat_byte) held_ok = 1'b0;
        if (cyc == exp_done_cyc) begin
            check("done_pulse", {30'd0, done1, done0}, exp_done_own ? 32'd2 : 32'd1);
            check("byte_held", {31'd0, held_ok}, 32'd1);
            if (uart_mode == 1) check("err_with_done", {31'd0, err}, 32'd1);
            exp_done_cyc = -1;
        end
        if (uart_mode == 0) begin
            if (tx_enable) begin
                uart_phase = 1;
            end else if (uart_phase == 1) begin
                tx_rdy = 1'b0;
                uart_left = frame_len;
                uart_phase = 2;
            end else if (uart_phase == 2) begin
                uart_left--;
                if (uart_left == 0) begin
                    tx_rdy = 1'b1;
                    uart_phase = 0;
                    exp_done_cyc = cyc + 1;
                    exp_done_own = cur_own;
                end
            end
        end else if (uart_mode == 1) begin
            tx_rdy = 1'b1;
        end
        if (ack0) begin rem0--; req0 = 1'b0; byte0 = 8'h00; end
        if (ack1) begin rem1--; req1 = 1'b0; byte1 = 8'h00; end
        if (done0 && rem0 > 0) begin req0 = 1'b1; byte0 = val0; end
        if (done1 && rem1 > 0) begin req1 = 1'b1; byte1 = val1; end
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; byte0 = '0; byte1 = '0; tx_rdy = 1'b1;
        uart_mode = 0; uart_phase = 0; exp_done_cyc = -1; rem0 = 0; rem1 = 0;
        tick();
        reset = 1'b0;
        n_en = 0; n_ack0 = 0; n_ack1 = 0; n_done0 = 0; n_done1 = 0;
        t_en = 0; t_done0 = 0; t_done1 = 0;
        sb.delete();
        held_ok = 1'b1; lat_byte = '0; cur_own = 1'b0;
    endtask

    vec_t tbl[17];

    initial begin
        int t_req;
        int base;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(0,0,0,0,0,0,0,0,8'h00)};
        tbl[1]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0, mk(0,0,0,0,0,0,0,0,8'h00)};
        tbl[2]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0, mk(0,0,0,0,0,0,0,0,8'h00)};
        tbl[3]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, mk(1,1,1,0,0,0,0,0,8'h41)};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(1,0,0,0,0,0,0,0,8'h41)};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mk(1,0,0,0,0,0,0,0,8'h41)};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mk(1,0,0,0,0,0,0,0,8'h41)};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(1,0,0,0,1,0,0,0,8'h41)};
        tbl[8]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,0,0,0,0,0,0,0,8'h41)};
        tbl[9]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(1,1,0,1,0,0,1,0,8'h22)};
        tbl[10] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, mk(1,0,0,0,0,0,1,0,8'h22)};
        tbl[11] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, mk(1,0,0,0,0,0,1,0,8'h22)};
        tbl[12] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, mk(1,0,0,0,0,1,1,0,8'h22)};
        tbl[13] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, mk(0,0,0,0,0,0,1,0,8'h22)};
        tbl[14] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, mk(1,1,1,0,0,0,0,0,8'h11)};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(1,0,0,0,0,0,0,0,8'h11)};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(0,0,0,0,0,0,0,0,8'h00)};

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; byte0 = '0; byte1 = '0; tx_rdy = 1'b1;
        uart_mode = 0; frame_len = 20; exp_done_cyc = -1;
        tick();

        for (int i = 0; i < 17; i++) begin
            reset = tbl[i].rst; req0 = tbl[i].r0; byte0 = tbl[i].b0;
            req1 = tbl[i].r1; byte1 = tbl[i].b1; tx_rdy = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d", i), {16'd0, obs()}, {16'd0, tbl[i].exp});
        end

        // Single byte from requester 0, withdrawn and zeroed right after ack.
        do_reset();
        frame_len = 20;
        push(8'h41, 1'b0);
        arm0(8'h41, 1);
        t_req = cyc;
        repeat (40) step();
        check("t1_grant_latency", t_en - t_req, 1);
        check("t1_enables", n_en, 1);
        check("t1_ack0", n_ack0, 1);
        check("t1_ack1", n_ack1, 0);
        check("t1_done0", n_done0, 1);
        check("t1_done1", n_done1, 0);
        check("t1_busy_after", {31'd0, busy}, 0);

        // Round-robin with both requesters always pending.
        do_reset();
        frame_len = 5;
        push(8'h11, 1'b0); push(8'h22, 1'b1); push(8'h11, 1'b0); push(8'h22, 1'b1);
        arm0(8'h11, 2);
        arm1(8'h22, 2);
        repeat (70) step();
        check("t2_enables", n_en, 4);
        check("t2_sb_left", sb.size(), 0);
        check("t2_done0", n_done0, 2);
        check("t2_done1", n_done1, 2);

        // Requester 0 arrives while requester 1 is mid-frame.
        do_reset();
        frame_len = 20;
        push(8'h55, 1'b1); push(8'h66, 1'b0);
        arm1(8'h55, 1);
        repeat (5) step();
        check("t3_busy_in_frame", {31'd0, busy}, 1);
        arm0(8'h66, 1);
        repeat (50) step();
        check("t3_enables", n_en, 2);
        check("t3_gap_after_done1", t_en - t_done1, 2);
        check("t3_sb_left", sb.size(), 0);

        // UART never drops tx_rdy: abort, sticky err.
        do_reset();
        uart_mode = 1;
        push(8'h7E, 1'b0);
        arm0(8'h7E, 1);
        repeat (3) step();
        check("t4_err_before", {31'd0, err}, 0);
        repeat (12) step();
        check("t4_abort_delay", t_done0 - t_en, TIMEOUT + 2);
        check("t4_done0", n_done0, 1);
        uart_mode = 0;
        frame_len = 6;
        push(8'h33, 1'b1);
        arm1(8'h33, 1);
        repeat (20) step();
        check("t4_later_done1", n_done1, 1);
        check("t4_err_sticky", {31'd0, err}, 1);
        do_reset();
        check("t4_err_cleared", {31'd0, err}, 0);

        // Reset during WAIT_HI, then a grant blocked by a busy UART.
        frame_len = 20;
        push(8'h5A, 1'b0);
        arm0(8'h5A, 1);
        repeat (6) step();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        uart_phase = 0;
        exp_done_cyc = -1;
        check("t5_reset_outputs", {28'd0, busy, err, done0, done1}, 0);
        uart_mode = 2;
        tx_rdy = 1'b0;
        repeat (4) step();
        check("t5_no_done", n_done0, 0);
        push(8'h5B, 1'b0);
        arm0(8'h5B, 1);
        base = n_ack0;
        repeat (5) step();
        check("t5_blocked_ack", n_ack0 - base, 0);
        check("t5_blocked_busy", {31'd0, busy}, 0);
        tx_rdy = 1'b1;
        uart_mode = 0;
        repeat (3) step();
        check("t5_released_ack", n_ack0 - base, 1);
        repeat (30) step();
        check("t5_sb_left", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
